// File: rtl/stage2_flatten_buffer_pkg.sv
// Shared stage-2 definitions for the pooling core and the flatten buffer.
package stage2_flatten_buffer_pkg;

  // Pooling core output geometry, reused by the flatten buffer.
  localparam int ST2_Pool_CI  = 3;
  localparam int ST2_Pool_IBW = 19;

  // Pooled points per feature map (6x6).
  localparam int ST2_Flat_PTS = 36;

  // Read FSM encoding.
  localparam logic [0:0] FLAT_IDLE  = 1'b0;
  localparam logic [0:0] FLAT_DRAIN = 1'b1;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int st2_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stage2_flatten_bank.sv
// One feature-map bank: a whole pooled point (all channels) is written per
// beat, and a single (channel, point) element is read combinationally.
module stage2_flatten_bank #(
  parameter int CI         = 3,
  parameter int IBW        = 19,
  parameter int NUM_POINTS = 36,
  parameter int PT_W       = 6,
  parameter int CH_W       = 2
) (
  input  logic                clk,
  input  logic                i_wr_en,
  input  logic [PT_W-1:0]     i_wr_pt,
  input  logic [CI*IBW-1:0]   i_wr_data,
  input  logic [CH_W-1:0]     i_rd_ch,
  input  logic [PT_W-1:0]     i_rd_pt,
  output logic [IBW-1:0]      o_rd_data
);

  logic [IBW-1:0] ch_rd_data [CI];

  // One storage column per channel so each channel has a single writer.
  for (genvar gi = 0; gi < CI; gi++) begin : g_ch
    logic [IBW-1:0] mem_q [NUM_POINTS];

    // Contents need no reset: the full flag guarantees a map is completely
    // written before any element of it is read.
    always_ff @(posedge clk) begin
      if (i_wr_en) begin
        mem_q[i_wr_pt] <= i_wr_data[gi*IBW +: IBW];
      end
    end

    assign ch_rd_data[gi] = mem_q[i_rd_pt];
  end

  // Channel select for the element read port.
  always_comb begin
    o_rd_data = '0;
    for (int c = 0; c < CI; c++) begin
      if (i_rd_ch == CH_W'(c)) begin
        o_rd_data = ch_rd_data[c];
      end
    end
  end

endmodule

// File: rtl/stage2_flatten_buffer.sv
// Flatten buffer: captures point-major pooled points into ping-pong banks
// and replays each completed map channel-major over valid/ready.
module stage2_flatten_buffer
  import stage2_flatten_buffer_pkg::*;
#(
  parameter int CI         = ST2_Pool_CI,
  parameter int IBW        = ST2_Pool_IBW,
  parameter int NUM_POINTS = ST2_Flat_PTS,
  parameter int IDX_W      = $clog2(CI*NUM_POINTS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_in_valid,
  input  logic [CI*IBW-1:0]   i_in_fmap,
  output logic                o_ot_valid,
  input  logic                i_ot_ready,
  output logic [IBW-1:0]      o_ot_data,
  output logic [IDX_W-1:0]    o_ot_idx,
  output logic                o_ot_last,
  output logic                o_overflow
);

  localparam int PT_W = st2_width(NUM_POINTS);
  localparam int CH_W = st2_width(CI);
  localparam logic [PT_W-1:0]  PT_LAST  = PT_W'(NUM_POINTS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CI*NUM_POINTS - 1);

  // Bank bookkeeping
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [PT_W-1:0]  wr_pt_q, wr_pt_d;
  logic             overflow_q, overflow_d;

  // Read FSM and output registers
  logic [0:0]       state_q, state_d;
  logic             valid_q, valid_d;
  logic [IBW-1:0]   data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
  logic [PT_W-1:0]  rd_pt_q, rd_pt_d;

  logic             wr_fire, wr_drop, wr_done;
  logic             rd_accept, rd_done;
  logic [IDX_W-1:0] idx_inc;
  logic [1:0]       bank_wr_en;
  logic [IBW-1:0]   bank_rd_data [2];

  // Write side: accept a point into the current bank or drop it when full.
  always_comb begin
    wr_fire    = i_in_valid & ~full_q[wr_bank_q];
    wr_drop    = i_in_valid &  full_q[wr_bank_q];
    wr_done    = wr_fire & (wr_pt_q == PT_LAST);
    wr_pt_d    = wr_pt_q;
    wr_bank_d  = wr_bank_q;
    overflow_d = overflow_q | wr_drop;
    if (wr_fire) begin
      if (wr_done) begin
        wr_pt_d   = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_pt_d   = wr_pt_q + 1'b1;
      end
    end
  end

  // Element walk: point is the fast index, channel the slow one. The next
  // address is also the bank read address so the element lands in the
  // output register on the same edge it is selected.
  always_comb begin
    rd_accept = (state_q == FLAT_DRAIN) & valid_q & i_ot_ready;
    rd_done   = rd_accept & last_q;
    rd_ch_d   = rd_ch_q;
    rd_pt_d   = rd_pt_q;
    if (state_q == FLAT_IDLE) begin
      if (full_q[rd_bank_q]) begin
        rd_ch_d = '0;
        rd_pt_d = '0;
      end
    end else if (rd_accept && !last_q) begin
      if (rd_pt_q == PT_LAST) begin
        rd_pt_d = '0;
        rd_ch_d = rd_ch_q + 1'b1;
      end else begin
        rd_pt_d = rd_pt_q + 1'b1;
      end
    end
  end

  // Read FSM: start a map from IDLE, then stream back-to-back until the
  // last element is accepted; the return through IDLE costs one cycle.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    data_d    = data_q;
    idx_d     = idx_q;
    last_d    = last_q;
    rd_bank_d = rd_bank_q;
    idx_inc   = idx_q + 1'b1;
    if (state_q == FLAT_IDLE) begin
      if (full_q[rd_bank_q]) begin
        valid_d = 1'b1;
        data_d  = bank_rd_data[rd_bank_q];
        idx_d   = '0;
        last_d  = (IDX_LAST == '0);
        state_d = FLAT_DRAIN;
      end
    end else begin
      if (rd_accept) begin
        if (last_q) begin
          valid_d   = 1'b0;
          last_d    = 1'b0;
          rd_bank_d = ~rd_bank_q;
          state_d   = FLAT_IDLE;
        end else begin
          data_d = bank_rd_data[rd_bank_q];
          idx_d  = idx_inc;
          last_d = (idx_inc == IDX_LAST);
        end
      end
    end
  end

  // Full flags: the write and read sides always touch different banks, so
  // a set and a clear on the same edge are independent.
  always_comb begin
    full_d = full_q;
    if (wr_done) begin
      full_d[wr_bank_q] = 1'b1;
    end
    if (rd_done) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  // Ping-pong banks
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign bank_wr_en[gi] = wr_fire & (wr_bank_q == 1'(gi));

    stage2_flatten_bank #(
      .CI         (CI),
      .IBW        (IBW),
      .NUM_POINTS (NUM_POINTS),
      .PT_W       (PT_W),
      .CH_W       (CH_W)
    ) u_bank (
      .clk       (clk),
      .i_wr_en   (bank_wr_en[gi]),
      .i_wr_pt   (wr_pt_q),
      .i_wr_data (i_in_fmap),
      .i_rd_ch   (rd_ch_d),
      .i_rd_pt   (rd_pt_d),
      .o_rd_data (bank_rd_data[gi])
    );
  end

  // State registers; reset drops any partial map and pending output.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_pt_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= FLAT_IDLE;
      valid_q    <= 1'b0;
      data_q     <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      rd_ch_q    <= '0;
      rd_pt_q    <= '0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_pt_q    <= wr_pt_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      rd_ch_q    <= rd_ch_d;
      rd_pt_q    <= rd_pt_d;
    end
  end

  assign o_ot_valid = valid_q;
  assign o_ot_data  = data_q;
  assign o_ot_idx   = idx_q;
  assign o_ot_last  = last_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_stage2_flatten_buffer.sv
// Bench for stage2_flatten_buffer with a small map (4 points, 3 channels).
module tb_stage2_flatten_buffer;

  localparam int CI    = 3;
  localparam int IBW   = 19;
  localparam int NP    = 4;
  localparam int NE    = CI*NP;
  localparam int IDX_W = $clog2(CI*NP);

  logic                clk = 1'b0;
  logic                reset_n;
  logic                in_valid;
  logic [CI*IBW-1:0]   in_fmap;
  logic                ot_valid;
  logic                ot_ready;
  logic [IBW-1:0]      ot_data;
  logic [IDX_W-1:0]    ot_idx;
  logic                ot_last;
  logic                overflow;

  always #5 clk = ~clk;

  stage2_flatten_buffer #(
    .CI(CI), .IBW(IBW), .NUM_POINTS(NP), .IDX_W(IDX_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_valid (in_valid),
    .i_in_fmap  (in_fmap),
    .o_ot_valid (ot_valid),
    .i_ot_ready (ot_ready),
    .o_ot_data  (ot_data),
    .o_ot_idx   (ot_idx),
    .o_ot_last  (ot_last),
    .o_overflow (overflow)
  );

  // Reference model: maps as lists of points, a flattened expected stream,
  // and a count of completed maps still occupying a bank.
  typedef struct { logic [IBW-1:0] data; int idx; } elem_t;
  elem_t             exp_q[$];
  logic [CI*IBW-1:0] cur_map[$];
  int                pending;
  bit                exp_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_count = 0;

  typedef struct {
    bit in_valid; bit ready;
    bit exp_valid; int exp_data; int exp_idx; bit exp_last;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [CI*IBW-1:0] mk_pt(input int base, input int p);
    logic [CI*IBW-1:0] v;
    for (int c = 0; c < CI; c++) v[c*IBW +: IBW] = IBW'(base + 100*c + p);
    return v;
  endfunction

  // Advance the model by one clock edge using the values about to be sampled.
  task automatic model_edge();
    if (!reset_n) begin
      exp_q.delete();
      cur_map.delete();
      pending = 0;
      exp_ovf = 1'b0;
      return;
    end
    if (in_valid) begin
      if (pending == 2) begin
        exp_ovf = 1'b1;
      end else begin
        cur_map.push_back(in_fmap);
        if (cur_map.size() == NP) begin
          for (int c = 0; c < CI; c++)
            for (int p = 0; p < NP; p++)
              exp_q.push_back('{data: cur_map[p][c*IBW +: IBW], idx: c*NP + p});
          cur_map.delete();
          pending++;
        end
      end
    end
    if (ot_valid && ot_ready) begin
      acc_count++;
      $display("accept idx=%0d data=%05h cycle=%0d", ot_idx, ot_data, cyc);
      if (exp_q.size() > 0) begin
        if (exp_q[0].idx == NE-1) pending--;
        void'(exp_q.pop_front());
      end
    end
  endtask

  // Scoreboard comparison on every observed cycle.
  task automatic observe();
    if (ot_valid) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_valid");
      end else begin
        check("sb_data", 32'(ot_data), 32'(exp_q[0].data));
        check("sb_idx",  32'(ot_idx),  32'(exp_q[0].idx));
        check("sb_last", 32'(ot_last), 32'(exp_q[0].idx == NE-1));
      end
    end
    check("sb_overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    observe();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int neg_seen;
    int idx0_cyc[$];
    int last_cyc[$];
    bit seen;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_fmap  = '0;
    ot_ready = 1'b0;
    pending  = 0;
    exp_ovf  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(ot_valid), 32'd0);
    check("rst_data",  32'(ot_data),  32'd0);
    check("rst_idx",   32'(ot_idx),   32'd0);
    check("rst_last",  32'(ot_last),  32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic order, table-driven: record 0 is the cycle that writes the last
    // point; the first element follows one cycle later.
    for (int k = 0; k < 14; k++) begin
      tbl[k].in_valid  = (k == 0);
      tbl[k].ready     = 1'b1;
      tbl[k].exp_valid = (k >= 1 && k <= NE);
      tbl[k].exp_data  = 100*((k-1)/NP) + (k-1)%NP;
      tbl[k].exp_idx   = k-1;
      tbl[k].exp_last  = (k == NE);
    end
    ot_ready = 1'b1;
    for (int p = 0; p < NP-1; p++) begin
      in_valid = 1'b1;
      in_fmap  = mk_pt(0, p);
      tick();
    end
    for (int k = 0; k < 14; k++) begin
      in_valid = tbl[k].in_valid;
      if (tbl[k].in_valid) in_fmap = mk_pt(0, NP-1);
      ot_ready = tbl[k].ready;
      tick();
      check("tbl_valid", 32'(ot_valid), 32'(tbl[k].exp_valid));
      if (tbl[k].exp_valid) begin
        check("tbl_data", 32'(ot_data), 32'(tbl[k].exp_data));
        check("tbl_idx",  32'(ot_idx),  32'(tbl[k].exp_idx));
        check("tbl_last", 32'(ot_last), 32'(tbl[k].exp_last));
      end
    end

    // Backpressure with ready pattern 1,0,0,1
    start = acc_count;
    for (int j = 0; j < 200 && (acc_count - start) < NE; j++) begin
      in_valid = (j < NP);
      if (j < NP) in_fmap = mk_pt(0, j);
      ot_ready = (j % 4 == 0) || (j % 4 == 3);
      tick();
    end
    in_valid = 1'b0;
    check("bp_count", 32'(acc_count - start), 32'(NE));
    check("bp_valid_low", 32'(ot_valid), 32'd0);

    // Negative channel-1 values pass bit-exact
    ot_ready = 1'b1;
    neg_seen = 0;
    for (int p = 0; p < NP; p++) begin
      in_valid = 1'b1;
      in_fmap  = mk_pt(0, p);
      in_fmap[IBW +: IBW] = 19'h7FFFB;
      tick();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (ot_valid && int'(ot_idx) >= NP && int'(ot_idx) < 2*NP) begin
        neg_seen++;
        check("neg_elem", 32'(ot_data), 32'h7FFFB);
      end
    end
    check("neg_seen", 32'(neg_seen), 32'(NP));

    // Ping-pong: two maps back-to-back, one idle cycle between them
    ot_ready = 1'b1;
    for (int j = 0; j < 60; j++) begin
      in_valid = (j < 2*NP);
      if (j < 2*NP) in_fmap = mk_pt((j < NP) ? 2000 : 3000, j % NP);
      tick();
      if (ot_valid && ot_idx == '0) idx0_cyc.push_back(cyc);
      if (ot_valid && ot_last) last_cyc.push_back(cyc);
    end
    in_valid = 1'b0;
    check("pp_maps", 32'(idx0_cyc.size()), 32'd2);
    if (idx0_cyc.size() >= 2 && last_cyc.size() >= 1)
      check("pp_gap", 32'(idx0_cyc[1] - last_cyc[0]), 32'd2);
    else
      fail_now("pp_gap_missing_beats");
    check("pp_ovf", 32'(overflow), 32'd0);

    // Overflow: three maps with the consumer stalled
    ot_ready = 1'b0;
    for (int j = 0; j < 3*NP; j++) begin
      in_valid = 1'b1;
      in_fmap  = mk_pt(4000 + (j / NP)*1000, j % NP);
      tick();
      if (j == 2*NP-1) check("ovf_pre", 32'(overflow), 32'd0);
      if (j == 2*NP)   check("ovf_set", 32'(overflow), 32'd1);
    end
    in_valid = 1'b0;
    start = acc_count;
    ot_ready = 1'b1;
    for (int j = 0; j < 40; j++) tick();
    check("ovf_drain_count", 32'(acc_count - start), 32'(2*NE));
    check("ovf_idle", 32'(ot_valid), 32'd0);

    // Reset in the middle of a drain with a partial map pending
    ot_ready = 1'b0;
    for (int p = 0; p < NP; p++) begin
      in_valid = 1'b1;
      in_fmap  = mk_pt(7000, p);
      tick();
    end
    in_valid = 1'b0;
    ot_ready = 1'b1;
    for (int j = 0; j < 3; j++) tick();
    for (int p = 0; p < 2; p++) begin
      in_valid = 1'b1;
      in_fmap  = mk_pt(8000, p);
      tick();
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    tick();
    check("mid_rst_valid", 32'(ot_valid), 32'd0);
    check("mid_rst_ovf",   32'(overflow), 32'd0);
    reset_n = 1'b1;
    start = acc_count;
    seen  = 1'b0;
    for (int j = 0; j < 30; j++) begin
      in_valid = (j < NP);
      if (j < NP) in_fmap = mk_pt(9000, j);
      tick();
      if (ot_valid && !seen) begin
        seen = 1'b1;
        check("post_rst_idx",  32'(ot_idx),  32'd0);
        check("post_rst_data", 32'(ot_data), 32'd9000);
      end
    end
    in_valid = 1'b0;
    check("post_rst_count", 32'(acc_count - start), 32'(NE));

    // Randomized traffic against the model
    for (int j = 0; j < 600; j++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < CI; c++) in_fmap[c*IBW +: IBW] = IBW'($urandom);
      ot_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    ot_ready = 1'b1;
    for (int j = 0; j < 300 && (exp_q.size() > 0 || ot_valid); j++) tick();
    check("rand_drain_empty", 32'(exp_q.size()), 32'd0);
    check("rand_final_valid", 32'(ot_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
